vram_fetch: RTL and testbench

Video-memory fetch and arbitration stage directly upstream of the Vector-06C display block. On each column request it reads the four 8 KB bit-planes of one display address from the shared 8-bit main RAM and presents them as one 32-bit word. It also arbitrates CPU accesses to the same RAM port, and video bursts always take precedence over CPU accesses.

---
 rtl/vram_pkg.sv | 12 +
 rtl/vram_fetch.sv | 154 +++++++++++++++
 tb/tb_vram_fetch.sv | 277 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/vram_pkg.sv
// rtl/vram_pkg.sv - shared state type and plane constants for the video fetch stage
package vram_pkg;

  typedef enum logic [1:0] {IDLE, VID, CPU, CACK} vram_state_t;

  // Upper three address bits of each bit-plane: 0x8000, 0xA000, 0xC000, 0xE000
  localparam logic [3:0][2:0] PLANE_BASE = {3'b111, 3'b110, 3'b101, 3'b100};

  // Byte lane of vdata that each plane lands in; plane 0 is the MSB byte
  localparam logic [3:0][1:0] PLANE_BYTE = {2'd0, 2'd1, 2'd2, 2'd3};

endpackage

// File: rtl/vram_fetch.sv
// rtl/vram_fetch.sv - four-plane video fetch with CPU arbitration on the shared RAM port
module vram_fetch
  import vram_pkg::*;
(
  input  logic        clk_sys,
  input  logic        reset,
  input  logic [12:0] vaddr,
  input  logic        vreq,
  output logic [31:0] vdata,
  output logic        vvalid,
  output logic        overrun,
  input  logic        cpu_req,
  input  logic        cpu_we,
  input  logic [15:0] cpu_addr,
  input  logic [7:0]  cpu_dout,
  output logic [7:0]  cpu_din,
  output logic        cpu_ack,
  output logic [15:0] mem_addr,
  output logic        mem_rd,
  output logic        mem_wr,
  output logic [7:0]  mem_dout,
  input  logic [7:0]  mem_din,
  input  logic        mem_ready
);

  vram_state_t      state, state_nxt;
  logic             pending;
  logic [12:0]      pend_addr;
  logic [12:0]      burst_addr;
  logic [1:0]       cnt, cnt_nxt;
  logic [3:0][7:0]  shadow, shadow_nxt;
  logic [15:0]      mem_addr_nxt;
  logic [7:0]       mem_dout_nxt;
  logic             mem_rd_nxt, mem_wr_nxt;
  logic             mem_done;
  logic             burst_start, burst_done, cpu_done;

  assign mem_done = (mem_rd | mem_wr) & mem_ready;

  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt    = state;
    cnt_nxt      = cnt;
    shadow_nxt   = shadow;
    mem_addr_nxt = mem_addr;
    mem_dout_nxt = mem_dout;
    mem_rd_nxt   = 1'b0;
    mem_wr_nxt   = 1'b0;
    burst_start  = 1'b0;
    burst_done   = 1'b0;
    cpu_done     = 1'b0;
    case (state)
      IDLE: begin
        // A vreq arriving this cycle is not yet pending but still blocks the CPU
        if (pending) begin
          state_nxt    = VID;
          cnt_nxt      = 2'd0;
          burst_start  = 1'b1;
          mem_rd_nxt   = 1'b1;
          mem_addr_nxt = {PLANE_BASE[0], pend_addr};
        end else if (cpu_req && !vreq) begin
          state_nxt    = CPU;
          mem_addr_nxt = cpu_addr;
          mem_wr_nxt   = cpu_we;
          mem_rd_nxt   = !cpu_we;
          if (cpu_we) begin
            mem_dout_nxt = cpu_dout;
          end
        end
      end
      VID: begin
        mem_rd_nxt = 1'b1;
        if (mem_done) begin
          shadow_nxt[PLANE_BYTE[cnt]] = mem_din;
          cnt_nxt = cnt + 2'd1;
          if (cnt == 2'd3) begin
            burst_done = 1'b1;
            mem_rd_nxt = 1'b0;
            state_nxt  = IDLE;
          end else begin
            mem_addr_nxt = {PLANE_BASE[cnt_nxt], burst_addr};
          end
        end
      end
      CPU: begin
        mem_rd_nxt = mem_rd;
        mem_wr_nxt = mem_wr;
        if (mem_done) begin
          cpu_done   = 1'b1;
          mem_rd_nxt = 1'b0;
          mem_wr_nxt = 1'b0;
          state_nxt  = CACK;
        end
      end
      CACK: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      pending    <= 1'b0;
      pend_addr  <= '0;
      burst_addr <= '0;
      overrun    <= 1'b0;
      cnt        <= 2'd0;
      shadow     <= '0;
      vdata      <= '0;
      vvalid     <= 1'b0;
      cpu_din    <= '0;
      cpu_ack    <= 1'b0;
      mem_addr   <= '0;
      mem_rd     <= 1'b0;
      mem_wr     <= 1'b0;
      mem_dout   <= '0;
    end else begin
      // The captured address moves into burst_addr at start, freeing the latch for the next column
      if (vreq) begin
        pending   <= 1'b1;
        pend_addr <= vaddr;
        if (pending && !burst_start) begin
          overrun <= 1'b1;
        end
      end else if (burst_start) begin
        pending <= 1'b0;
      end
      if (burst_start) begin
        burst_addr <= pend_addr;
      end
      cnt      <= cnt_nxt;
      shadow   <= shadow_nxt;
      vvalid   <= burst_done;
      if (burst_done) begin
        vdata <= shadow_nxt;
      end
      cpu_ack  <= cpu_done;
      if (cpu_done && mem_rd) begin
        cpu_din <= mem_din;
      end
      mem_addr <= mem_addr_nxt;
      mem_rd   <= mem_rd_nxt;
      mem_wr   <= mem_wr_nxt;
      mem_dout <= mem_dout_nxt;
    end
  end

endmodule

// File: tb/tb_vram_fetch.sv
// tb/tb_vram_fetch.sv - directed self-checking bench for vram_fetch
module tb_vram_fetch;

  logic        clk_sys  = 1'b0;
  logic        reset    = 1'b1;
  logic [12:0] vaddr    = '0;
  logic        vreq     = 1'b0;
  logic [31:0] vdata;
  logic        vvalid;
  logic        overrun;
  logic        cpu_req  = 1'b0;
  logic        cpu_we   = 1'b0;
  logic [15:0] cpu_addr = '0;
  logic [7:0]  cpu_dout = '0;
  logic [7:0]  cpu_din;
  logic        cpu_ack;
  logic [15:0] mem_addr;
  logic        mem_rd;
  logic        mem_wr;
  logic [7:0]  mem_dout;
  logic [7:0]  mem_din;
  logic        mem_ready;

  logic [7:0]  mem [0:65535];
  int          ws       = 0;
  int          wcnt     = 0;
  int          wr_cnt   = 0;
  int          ack_cnt  = 0;
  int          hold_err = 0;
  logic        hold_chk = 1'b0;
  logic [17:0] held     = '0;
  int          n_checks = 0;
  int          n_fail   = 0;

  always #5 clk_sys = ~clk_sys;

  vram_fetch dut (
    .clk_sys   (clk_sys),
    .reset     (reset),
    .vaddr     (vaddr),
    .vreq      (vreq),
    .vdata     (vdata),
    .vvalid    (vvalid),
    .overrun   (overrun),
    .cpu_req   (cpu_req),
    .cpu_we    (cpu_we),
    .cpu_addr  (cpu_addr),
    .cpu_dout  (cpu_dout),
    .cpu_din   (cpu_din),
    .cpu_ack   (cpu_ack),
    .mem_addr  (mem_addr),
    .mem_rd    (mem_rd),
    .mem_wr    (mem_wr),
    .mem_dout  (mem_dout),
    .mem_din   (mem_din),
    .mem_ready (mem_ready)
  );

  // RAM model: ws wait cycles before each access completes
  assign mem_ready = (wcnt >= ws);
  assign mem_din   = mem[mem_addr];

  always @(posedge clk_sys) begin
    if (!(mem_rd || mem_wr) || mem_ready) wcnt <= 0;
    else wcnt <= wcnt + 1;
    if (reset) begin
      mem[16'h8123] <= 8'h11; mem[16'hA123] <= 8'h22;
      mem[16'hC123] <= 8'h33; mem[16'hE123] <= 8'h44;
      mem[16'h8002] <= 8'h55; mem[16'hA002] <= 8'h66;
      mem[16'hC002] <= 8'h77; mem[16'hE002] <= 8'h88;
    end else if (mem_wr && mem_ready) begin
      mem[mem_addr] <= mem_dout;
    end
    if (mem_wr && mem_ready) wr_cnt <= wr_cnt + 1;
    if (cpu_ack) ack_cnt <= ack_cnt + 1;
    hold_chk <= (mem_rd || mem_wr) && !mem_ready;
    held     <= {mem_rd, mem_wr, mem_addr};
  end

  always @(negedge clk_sys) begin
    if (!reset && hold_chk && ({mem_rd, mem_wr, mem_addr} != held)) hold_err <= hold_err + 1;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_sys);
    #1;
  endtask

  task automatic wait_vvalid(output int n);
    n = -1;
    for (int i = 1; i <= 40; i++) begin
      tick();
      if (vvalid) begin
        n = i;
        break;
      end
    end
  endtask

  task automatic wait_ack(output int n);
    n = -1;
    for (int i = 1; i <= 20; i++) begin
      tick();
      if (cpu_ack) begin
        n = i;
        break;
      end
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int   n;
    int   vv_cyc;
    int   ack_cyc;
    logic drop;

    repeat (3) tick();
    chk("rst_vdata", vdata, 32'h0);
    chk("rst_vvalid", vvalid, 1'b0);
    chk("rst_overrun", overrun, 1'b0);
    chk("rst_cpu_din", cpu_din, 8'h00);
    chk("rst_cpu_ack", cpu_ack, 1'b0);
    chk("rst_mem_addr", mem_addr, 16'h0000);
    chk("rst_mem_rd", mem_rd, 1'b0);
    chk("rst_mem_wr", mem_wr, 1'b0);
    chk("rst_mem_dout", mem_dout, 8'h00);
    reset = 1'b0;
    repeat (2) tick();

    // basic burst, zero wait states
    vaddr = 13'h0123; vreq = 1'b1;
    tick();
    vreq = 1'b0;
    chk("burst_rd_e0", mem_rd, 1'b0);
    for (int k = 1; k <= 5; k++) begin
      tick();
      if (k < 5) begin
        chk("burst_vvalid_early", vvalid, 1'b0);
        chk("burst_rd_held", mem_rd, 1'b1);
        chk("burst_addr", mem_addr, 32'h8123 + 32'(k - 1) * 32'h2000);
      end else begin
        chk("burst_vvalid_e5", vvalid, 1'b1);
        chk("burst_vdata", vdata, 32'h11223344);
        chk("burst_rd_done", mem_rd, 1'b0);
      end
    end
    tick();
    chk("burst_vvalid_pulse", vvalid, 1'b0);

    // CPU write, held one cycle past ack
    cpu_addr = 16'h4000; cpu_dout = 8'hA5; cpu_we = 1'b1; cpu_req = 1'b1;
    wait_ack(n);
    chk("wr_ack_seen", n > 0, 1'b1);
    tick();
    cpu_req = 1'b0; cpu_we = 1'b0;
    repeat (4) tick();
    chk("wr_count", wr_cnt, 1);
    chk("wr_ack_count", ack_cnt, 1);
    chk("wr_data", mem[16'h4000], 8'hA5);

    // CPU read back
    cpu_req = 1'b1;
    wait_ack(n);
    chk("rd_ack_seen", n > 0, 1'b1);
    chk("rd_cpu_din", cpu_din, 8'hA5);
    tick();
    cpu_req = 1'b0;
    repeat (4) tick();
    chk("rd_ack_count", ack_cnt, 2);
    chk("rd_no_write", wr_cnt, 1);

    // simultaneous vreq and cpu_req: burst first
    vaddr = 13'h0123; vreq = 1'b1; cpu_req = 1'b1; cpu_we = 1'b0;
    vv_cyc = -1; ack_cyc = -1; drop = 1'b0;
    for (int i = 1; i <= 30; i++) begin
      tick();
      if (i == 1) vreq = 1'b0;
      if (drop) begin
        cpu_req = 1'b0;
        drop = 1'b0;
      end
      if (vvalid && vv_cyc < 0) begin
        vv_cyc = i;
        chk("sim_vdata", vdata, 32'h11223344);
      end
      if (cpu_ack && ack_cyc < 0) begin
        ack_cyc = i;
        drop = 1'b1;
        chk("sim_cpu_din", cpu_din, 8'hA5);
      end
    end
    chk("sim_vvalid_cyc", vv_cyc, 6);
    chk("sim_ack_after", (ack_cyc > vv_cyc) && (vv_cyc > 0), 1'b1);
    chk("sim_ack_count", ack_cnt, 3);

    // overrun: two vreqs during a burst
    chk("ovr_before", overrun, 1'b0);
    vaddr = 13'h0123; vreq = 1'b1;
    tick();
    vreq = 1'b0;
    tick();
    vaddr = 13'h0001; vreq = 1'b1;
    tick();
    chk("ovr_first", overrun, 1'b0);
    vaddr = 13'h0002;
    tick();
    vreq = 1'b0;
    chk("ovr_set", overrun, 1'b1);
    wait_vvalid(n);
    chk("ovr_burst1_lat", n, 2);
    chk("ovr_burst1_vdata", vdata, 32'h11223344);
    wait_vvalid(n);
    chk("ovr_burst2_lat", n, 5);
    chk("ovr_burst2_vdata", vdata, 32'h55667788);
    chk("ovr_sticky", overrun, 1'b1);

    // two wait states on every access
    repeat (2) tick();
    ws = 2;
    vaddr = 13'h0123; vreq = 1'b1;
    tick();
    vreq = 1'b0;
    wait_vvalid(n);
    chk("ws_latency", n, 13);
    chk("ws_vdata", vdata, 32'h11223344);
    chk("ws_hold_stable", hold_err, 0);
    ws = 0;
    repeat (2) tick();

    // reset after plane 1 completes
    vaddr = 13'h0002; vreq = 1'b1;
    tick();
    vreq = 1'b0;
    repeat (3) tick();
    chk("rst_mid_rd_before", mem_rd, 1'b1);
    reset = 1'b1;
    #1;
    chk("rst_mid_rd_async", mem_rd, 1'b0);
    chk("rst_mid_vvalid", vvalid, 1'b0);
    chk("rst_mid_vdata", vdata, 32'h0);
    chk("rst_mid_overrun", overrun, 1'b0);
    chk("rst_mid_ack", cpu_ack, 1'b0);
    repeat (2) tick();
    reset = 1'b0;
    n = 0;
    repeat (8) begin
      tick();
      if (vvalid) n++;
    end
    chk("rst_mid_no_vvalid", n, 0);
    chk("rst_mid_vdata_hold", vdata, 32'h0);
    vaddr = 13'h0123; vreq = 1'b1;
    tick();
    vreq = 1'b0;
    wait_vvalid(n);
    chk("rst_clean_lat", n, 5);
    chk("rst_clean_vdata", vdata, 32'h11223344);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
